// File: rtl/seg_pkg.sv
// seg_pkg: shared segment polarity, blanking constants, hex patterns and frame type for the scan driver.
package seg_pkg;
  localparam logic SEG_ON = 1'b0;
  localparam logic SEG_OFF = 1'b1;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] AN_OFF = 8'hFF;
  localparam logic [6:0] HEX_PAT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  en;
  } frame_t;
endpackage

// File: rtl/seg_hex_decode.sv
// seg_hex_decode: 4-bit nibble to active-low {g..a} segment pattern.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] pat
);
  assign pat = HEX_PAT[nib];
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: double-buffered 8-digit hex display driver with boundary swap and post-change blanking.
// Define SEG_LZ_SUPPRESS_EN to blank leading zero digits (mask fixed at swap time).
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int BLANK_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  dig_id,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [31:0] wr_data,
  input  logic [7:0]  wr_dp,
  input  logic [7:0]  wr_en,
  output logic [7:0]  an_n,
  output logic [7:0]  seg_n,
  output logic        frame_done
);
  localparam int CW = BLANK_CYCLES > 1 ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
  localparam logic BLANK_EN = BLANK_CYCLES != 0;
  frame_t active, shadow, active_nx, shown;
  logic pending, accept, change, boundary, blank, lit;
  logic [2:0] dig_q;
  logic [CW-1:0] cnt, cnt_nx;
  logic [6:0] pat;
  logic [7:0] an_nx, seg_nx;
`ifdef SEG_LZ_SUPPRESS_EN
  // Digits above the highest nonzero nibble are leading zeros; digit 0 always stays.
  function automatic logic [7:0] lz_en(input frame_t f);
    logic lead;
    lead = 1'b1;
    lz_en = f.en;
    for (int i = 7; i >= 1; i--) begin
      if (f.data[i*4+:4] != 4'h0) lead = 1'b0;
      if (lead) lz_en[i] = 1'b0;
    end
  endfunction
  always_comb begin
    shown = shadow;
    shown.en = lz_en(shadow);
  end
`else
  assign shown = shadow;
`endif
  assign wr_ready = !pending;
  assign accept = wr_valid && !pending;
  assign change = dig_id != dig_q;
  assign boundary = dig_q == 3'd7 && dig_id == 3'd0;
  assign active_nx = (boundary && pending) ? shown : active;
  assign blank = BLANK_EN && (change || cnt != '0);
  assign lit = !blank && active_nx.en[dig_id];
  seg_hex_decode u_dec (
    .nib(active_nx.data[dig_id*4+:4]),
    .pat(pat)
  );
  always_comb begin
    cnt_nx = (BLANK_EN && change) ? LOAD : (cnt != '0) ? cnt - 1'b1 : '0;
    an_nx = lit ? ~(8'd1 << dig_id) : AN_OFF;
    seg_nx = lit ? {active_nx.dp[dig_id] ? SEG_ON : SEG_OFF, pat} : SEG_BLANK;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dig_q <= '0;
      cnt <= '0;
      pending <= 1'b0;
      active <= '0;
      shadow <= '0;
      an_n <= AN_OFF;
      seg_n <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      dig_q <= dig_id;
      cnt <= cnt_nx;
      active <= active_nx;
      pending <= accept ? 1'b1 : boundary ? 1'b0 : pending;
      if (accept) shadow <= '{data: wr_data, dp: wr_dp, en: wr_en};
      an_n <= an_nx;
      seg_n <= seg_nx;
      frame_done <= boundary;
    end
endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Display-side consumer of the 3-bit digit scan index produced by the scan counter. Holds a double-buffered 8-digit hex frame, written through a valid/ready port, and drives active-low anode and segment lines for the currently indexed digit. New frames swap in only at frame boundaries, when the index wraps 7→0, so the display never tears. A configurable blanking gap after every index change suppresses ghosting.

## Interface
- BLANK_CYCLES, default 2: clock cycles of full blank inserted after each dig_id change; 0 disables blanking.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- dig_id  in  3  scan index from the scan counter; cycles 0..7.
- wr_valid  in  1  frame write request.
- wr_ready  out  1  shadow buffer free; a write is accepted when wr_valid && wr_ready.
- wr_data  in  32  8 hex nibbles; nibble k = wr_data[4k+3:4k] is shown on digit k.
- wr_dp  in  8  per-digit decimal point, 1 = lit.
- wr_en  in  8  per-digit enable, 1 = digit shown.
- an_n  out  8  anode select, active-low, one-hot-low when driving.
- seg_n  out  8  {dp,g,f,e,d,c,b,a}, active-low.
- frame_done  out  1  one-cycle pulse on each frame boundary.

## Operation
- Shadow buffer {data, dp, en} is loaded on accept. pending is set on accept; wr_ready = !pending.
- dig_q is a registered copy of dig_id. change = (dig_id != dig_q). boundary = (dig_q == 7 && dig_id == 0).
- On boundary: active ← shadow only if pending was already set before this cycle; pending is then cleared and frame_done pulses.
- Write accepted in a boundary cycle: held until the next boundary.
- Blank counter: loaded with BLANK_CYCLES-1 on change; decrements to 0 otherwise. Outputs are blanked in the change cycle and while the counter is nonzero.
- Driving digit k = dig_q: an_n = ~(1<<k), seg_n = {~dp[k], hex7(nibble k)}.
- Disabled digit (en[k]=0): an_n = 8'hFF, seg_n = 8'hFF.
- Hex decode (active-low {g..a}): 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78, 8→7'h00, 9→7'h10, A→7'h08, b→7'h03, C→7'h46, d→7'h21, E→7'h06, F→7'h0E.
- Arbitrary, non-sequential dig_id jumps are legal: each one counts as a change. Only a 7→0 step counts as a boundary.

## Timing
- Outputs registered: one cycle of latency from dig_id to an_n/seg_n when BLANK_CYCLES=0.
- With BLANK_CYCLES=N≥1, an_n/seg_n are 8'hFF for exactly N cycles after the change, then drive the digit.
- wr_ready falls the cycle after accept. It rises the cycle after the swapping boundary.
- Reset values: an_n=8'hFF, seg_n=8'hFF, wr_ready=1, frame_done=0, pending=0, dig_q=0, blank counter 0, active and shadow buffers all-zero. Because active en=0 after reset, the display stays dark until the first swap.
- Reset mid-operation discards any pending frame and the active frame.

## Configuration
- SEG_LZ_SUPPRESS_EN defined: leading-zero suppression. Scanning from digit 7 downward, enabled digits whose nibble is 0 are treated as disabled until the first nonzero nibble. Digit 0 is never suppressed. The suppression mask is computed once at swap time and stored with the active buffer.
- Undefined: every enabled digit is shown, including leading zeros.

## Structure
- Shared package seg_pkg: segment polarity constants, SEG_BLANK=8'hFF, AN_OFF=8'hFF, and the 16-entry hex pattern constants.
- One sub-module: seg_hex_decode, combinational, 4-bit nibble → 7-bit active-low pattern.
- Leading-zero mask logic sits in the top level under the macro.

## Test plan
- Reset release, dig_id stepping 0..7, no write → an_n=8'hFF, seg_n=8'hFF throughout; wr_ready=1.
- Write wr_data=32'h76543210, wr_en=8'hFF, wr_dp=8'h01, BLANK_CYCLES=0 → after the next 7→0 step, dig_id=0 gives an_n=8'hFE, seg_n=8'h40 one cycle later, and dig_id=3 gives an_n=8'hF7, seg_n=8'hB0.
- Accept write, then assert wr_valid again before the boundary → wr_ready=0 and the second frame is not accepted. On the boundary, frame_done=1 for one cycle, and wr_ready=1 on the following cycle.
- Write accepted exactly in a boundary cycle → active frame unchanged through the following frame; swap occurs at the next boundary.
- BLANK_CYCLES=2, dig_id 4→5 → an_n/seg_n=8'hFF for 2 cycles, then an_n=8'hDF.
- With SEG_LZ_SUPPRESS_EN: wr_data=32'h00000305, wr_en=8'hFF → digits 7..3 dark; digits 2, 1, 0 show 7'h30, 7'h40, 7'h12.
